// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and write-back source tags for the register file
// write side.
package writeback_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef logic [XLEN-1:0]           xlen_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic {
    WB_SRC_ALU  = 1'b0,
    WB_SRC_LOAD = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    xlen_t     data;
  } wb_port_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result channels, load issue/query and register file write port
// seen by the write-back arbiter.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_rd;
  xlen_t     alu_data;
  logic      alu_ready;

  logic      load_valid;
  reg_addr_t load_rd;
  xlen_t     load_data;
  logic      load_ready;

  logic      issue_valid;
  reg_addr_t issue_rd;

  reg_addr_t query_addr_1;
  reg_addr_t query_addr_2;
  logic      query_busy_1;
  logic      query_busy_2;

  logic      write_enable;
  reg_addr_t write_addr;
  xlen_t     write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output load_valid, load_rd, load_data,
    input  load_ready,
    output issue_valid, issue_rd,
    output query_addr_1, query_addr_2,
    input  query_busy_1, query_busy_2,
    input  write_enable, write_addr, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  load_valid, load_rd, load_data,
    output load_ready,
    input  issue_valid, issue_rd,
    input  query_addr_1, query_addr_2,
    output query_busy_1, query_busy_2,
    output write_enable, write_addr, write_data
  );

endinterface

// File: rtl/writeback_scoreboard.sv
// Pending-load bitmap: one bit per register, x0 never pending.
// Set beats clear when both hit the same index.
module writeback_scoreboard
  import writeback_arbiter_pkg::*;
(
  input  logic      i_Clock,
  input  logic      i_Reset,
  input  logic      i_Set,
  input  reg_addr_t i_Set_Rd,
  input  logic      i_Clear,
  input  reg_addr_t i_Clear_Rd,
  input  reg_addr_t i_Query_Addr_1,
  input  reg_addr_t i_Query_Addr_2,
  output logic      o_Busy_1,
  output logic      o_Busy_2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (i_Clear)
      pending_nxt[i_Clear_Rd] = 1'b0;
    if (i_Set)
      pending_nxt[i_Set_Rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  assign o_Busy_1 = pending[i_Query_Addr_1]
                  && (i_Query_Addr_1 != '0);
  assign o_Busy_2 = pending[i_Query_Addr_2]
                  && (i_Query_Addr_2 != '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register file write
// port, with load priority bounded by an ALU starvation counter.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Enable,
  writeback_arbiter_if.slave wb
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve;
  logic [CW-1:0] starve_nxt;
  logic          grant_alu;
  logic          grant_load;
  logic          accept;
  wb_src_e       src;
  reg_addr_t     sel_rd;
  xlen_t         sel_data;
  wb_port_t      port;

  // Load normally wins; a starved ALU gets one guaranteed slot.
  always_comb begin
    grant_load = wb.load_valid
              && (!wb.alu_valid || starve != LIMIT);
    grant_alu  = wb.alu_valid && !grant_load;
  end

  assign wb.alu_ready  = i_Enable && grant_alu;
  assign wb.load_ready = i_Enable && grant_load;
  assign accept = wb.alu_ready || wb.load_ready;
  assign src    = grant_load ? WB_SRC_LOAD : WB_SRC_ALU;

  always_comb begin
    sel_rd   = wb.alu_rd;
    sel_data = wb.alu_data;
    unique case (src)
      WB_SRC_LOAD: begin
        sel_rd   = wb.load_rd;
        sel_data = wb.load_data;
      end
      WB_SRC_ALU: begin
        sel_rd   = wb.alu_rd;
        sel_data = wb.alu_data;
      end
    endcase
  end

  always_comb begin
    starve_nxt = starve;
    if (i_Enable) begin
      if (wb.alu_valid && !grant_alu)
        starve_nxt = (starve == LIMIT) ? starve
                                       : starve + 1'b1;
      else
        starve_nxt = '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      starve <= '0;
      port   <= '0;
    end else begin
      starve  <= starve_nxt;
      port.en <= accept && (sel_rd != '0);
      if (accept) begin
        port.addr <= sel_rd;
        port.data <= sel_data;
      end
    end
  end

  assign wb.write_enable = port.en;
  assign wb.write_addr   = port.addr;
  assign wb.write_data   = port.data;

  writeback_scoreboard u_sb (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Set          (i_Enable && wb.issue_valid
                     && wb.issue_rd != '0),
    .i_Set_Rd       (wb.issue_rd),
    .i_Clear        (wb.load_ready),
    .i_Clear_Rd     (wb.load_rd),
    .i_Query_Addr_1 (wb.query_addr_1),
    .i_Query_Addr_2 (wb.query_addr_2),
    .o_Busy_1       (wb.query_busy_1),
    .o_Busy_2       (wb.query_busy_2)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, arbitration,
// starvation, scoreboard, x0 and stall behaviour.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic en;
  int   vecs;
  int   errs;

  writeback_arbiter_if wb ();

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .i_Enable (en),
    .wb       (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag,
                        input logic we,
                        input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(wb.write_enable), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(wb.write_addr), 32'(a));
      chk({tag, "_data"}, wb.write_data, d);
    end
  endtask

  task automatic idle();
    wb.alu_valid   = 1'b0;
    wb.load_valid  = 1'b0;
    wb.issue_valid = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b1;
    en  = 1'b1;
    wb.alu_valid    = 1'b0;
    wb.alu_rd       = '0;
    wb.alu_data     = '0;
    wb.load_valid   = 1'b0;
    wb.load_rd      = '0;
    wb.load_data    = '0;
    wb.issue_valid  = 1'b0;
    wb.issue_rd     = '0;
    wb.query_addr_1 = 5'd9;
    wb.query_addr_2 = 5'd5;
    #12;
    chk("rst_we", 32'(wb.write_enable), 32'd0);
    chk("rst_addr", 32'(wb.write_addr), 32'd0);
    chk("rst_data", wb.write_data, 32'd0);
    chk("rst_busy1", 32'(wb.query_busy_1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single ALU write, one-cycle latency
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd3;
    wb.alu_data  = 32'h1234_5678;
    #1;
    chk("alu_rdy", 32'(wb.alu_ready), 32'd1);
    chk("alu_lrdy", 32'(wb.load_ready), 32'd0);
    tick();
    idle();
    chk_wr("alu_n1", 1'b1, 5'd3, 32'h1234_5678);
    tick();
    chk_wr("alu_n2", 1'b0, 5'd0, 32'd0);

    // reset mid-write drops the write and clears scoreboard
    wb.alu_valid   = 1'b1;
    wb.alu_rd      = 5'd5;
    wb.alu_data    = 32'hDEAD_BEEF;
    wb.issue_valid = 1'b1;
    wb.issue_rd    = 5'd9;
    tick();
    idle();
    chk_wr("mid_pre", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("mid_busy_pre", 32'(wb.query_busy_1), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_we", 32'(wb.write_enable), 32'd0);
    chk("mid_busy1", 32'(wb.query_busy_1), 32'd0);
    chk("mid_busy2", 32'(wb.query_busy_2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // contention: load wins 4 times, then the ALU
    wb.alu_valid  = 1'b1;
    wb.alu_rd     = 5'd8;
    wb.alu_data   = 32'hBB;
    wb.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.load_rd   = 5'(7 + i);
      wb.load_data = 32'hAA + 32'(i);
      #1;
      chk("ct_lrdy", 32'(wb.load_ready), 32'd1);
      chk("ct_ardy", 32'(wb.alu_ready), 32'd0);
      tick();
      chk_wr("ct_load", 1'b1, 5'(7 + i), 32'hAA + 32'(i));
    end
    wb.load_rd   = 5'd11;
    wb.load_data = 32'hCC;
    #1;
    chk("ct5_ardy", 32'(wb.alu_ready), 32'd1);
    chk("ct5_lrdy", 32'(wb.load_ready), 32'd0);
    tick();
    chk_wr("ct5_alu", 1'b1, 5'd8, 32'hBB);
    chk("ct_reset_cnt", 32'(wb.load_ready), 32'd1);

    // build counter to 2, stall, then resume from 2
    tick();
    tick();
    en = 1'b0;
    #1;
    chk("st_ardy", 32'(wb.alu_ready), 32'd0);
    chk("st_lrdy", 32'(wb.load_ready), 32'd0);
    tick();
    chk("st_we", 32'(wb.write_enable), 32'd0);
    tick();
    chk("st_we2", 32'(wb.write_enable), 32'd0);
    en = 1'b1;
    #1;
    chk("st_res_l1", 32'(wb.load_ready), 32'd1);
    tick();
    chk_wr("st_res_w", 1'b1, 5'd11, 32'hCC);
    chk("st_res_l2", 32'(wb.load_ready), 32'd1);
    tick();
    chk("st_res_alu", 32'(wb.alu_ready), 32'd1);
    tick();
    idle();
    chk_wr("st_res_aw", 1'b1, 5'd8, 32'hBB);

    // scoreboard set / clear / set-wins
    wb.issue_valid = 1'b1;
    wb.issue_rd    = 5'd9;
    tick();
    idle();
    chk("sb_set", 32'(wb.query_busy_1), 32'd1);
    wb.query_addr_2 = 5'd9;
    wb.load_valid = 1'b1;
    wb.load_rd    = 5'd9;
    wb.load_data  = 32'h55;
    #1;
    chk("sb_lrdy", 32'(wb.load_ready), 32'd1);
    chk("sb_busy_same", 32'(wb.query_busy_2), 32'd1);
    tick();
    idle();
    chk_wr("sb_wr", 1'b1, 5'd9, 32'h55);
    chk("sb_clr", 32'(wb.query_busy_1), 32'd0);
    wb.load_valid  = 1'b1;
    wb.issue_valid = 1'b1;
    wb.issue_rd    = 5'd9;
    tick();
    idle();
    chk("sb_setwin", 32'(wb.query_busy_1), 32'd1);

    // x0: accepted, never written, never pending
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd0;
    wb.alu_data  = 32'hFFFF_FFFF;
    #1;
    chk("x0_rdy", 32'(wb.alu_ready), 32'd1);
    tick();
    idle();
    chk("x0_we", 32'(wb.write_enable), 32'd0);
    wb.issue_valid = 1'b1;
    wb.issue_rd    = 5'd0;
    wb.query_addr_1 = 5'd0;
    tick();
    idle();
    chk("x0_busy", 32'(wb.query_busy_1), 32'd0);

    // issue ignored while stalled
    en = 1'b0;
    wb.issue_valid = 1'b1;
    wb.issue_rd    = 5'd12;
    wb.query_addr_2 = 5'd12;
    tick();
    idle();
    en = 1'b1;
    #1;
    chk("st_issue", 32'(wb.query_busy_2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1);
  end

endmodule
